mult_seq_ctrl: RTL and testbench
================================

# mult_seq_ctrl

Sequencing controller that computes a W×W-bit unsigned product by driving a single 2×2-bit combinational multiplier slice over every digit pair of the operands and accumulating the shifted partial products. It sits between a requester using a valid/ready handshake and the small gate-level multiplier datapath. It trades latency for area and keeps the fault-simulated multiplier slice small while still supporting wide operands.

## Interface
- W, default 8: operand width in bits; even, ≥ 2.
- N (localparam) = W/2: digits per operand.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  requester presents operands.
- in_ready  output  1  controller can accept operands.
- op_a  input  W  multiplicand, sampled on accept.
- op_b  input  W  multiplier, sampled on accept.
- out_valid  output  1  product is available.
- out_ready  input  1  consumer takes the product.
- product  output  2W  unsigned op_a × op_b.
- busy  output  1  high while in RUN.

## Operation
- Accept occurs when in_valid && in_ready. On accept:
  - op_a and op_b are latched into internal registers a_q and b_q.
  - The accumulator is cleared.
  - Digit counters i (index into a) and j (index into b) are cleared.
- States:
  - IDLE: in_ready=1. On accept, go to RUN.
  - RUN: each cycle, the slice multiplies a_q[2i+1:2i] by b_q[2j+1:2j].
    - The 4-bit slice result is zero-extended and shifted left by 2(i+j).
    - It is added into a 2W-bit accumulator. The sum cannot exceed 2W bits, so no overflow occurs.
    - j increments each cycle. When j wraps from N-1 to 0, i increments.
    - After the pair (N-1, N-1), the state goes to DONE.
    - in_ready=0 throughout RUN.
  - DONE: out_valid=1 and product = accumulator, held stable until out_ready.
    - On out_ready without a new accept, go to IDLE.
    - in_ready = out_ready. If a new accept coincides with the output handshake, go directly to RUN with the new operands; no idle bubble is required.
- in_valid during RUN is ignored; the operands are not sampled.
- Reset asserted mid-operation: the operation is abandoned with no output, and all state is cleared.
- Zero operands are not short-circuited; latency is always fixed.

## Timing
- Reset values:
  - state = IDLE.
  - out_valid = 0, busy = 0, product = 0.
  - in_ready = 1, because it is decoded from state.
  - Counters, accumulator, a_q and b_q are all 0.
- Latency: for an accept at edge E0, RUN occupies N² cycles and out_valid rises immediately after edge E0+N². For W=8 this is 16 cycles.
- Throughput: with out_ready held high, one product is produced every N² + 1 cycles.
- in_ready, busy and out_valid are decoded from registered state only; there is no combinational path from in_valid or op_* to the outputs.
- in_ready depends combinationally on out_ready only in DONE.
- product is registered and changes only on the edge that leaves RUN.

## Structure
- Package mult_seq_pkg holds:
  - the state enum {IDLE, RUN, DONE}, 2 bits;
  - the constant for the digit width (2).
- Sub-module mult_digit_2x2: a 2-bit × 2-bit unsigned combinational multiplier with a 4-bit output, built from AND/XOR gate primitives so that it is fault-enumerable. It is instantiated exactly once.
- Controller body: FSM, i/j counters ($clog2(N) bits each, minimum 1), digit mux, shifter, 2W-bit adder, and output register.

## Test plan
- W=8, op_a=13, op_b=11, out_ready=1 → out_valid is high exactly 16 cycles after accept, product=143, followed by one IDLE cycle.
- W=8, op_a=255, op_b=255 → product=65025 (0xFE01). Checks the maximum-value accumulation without overflow.
- op_a=0, op_b=200 → product=0 after the full 16 cycles, with busy high for all 16.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → product is stable, in_ready=0, and a new in_valid is not accepted. Then out_ready=1 together with in_valid (7×9) → back-to-back accept, and product=63 after a further 16 cycles.
- Drive in_valid with op_a=3, op_b=3 during RUN of a 10×10 job → the first result is 100 and the 3×3 operands are never latched.
- Assert rst_n low at RUN cycle 8 → out_valid=0, product=0, in_ready=1 immediately. A subsequent 6×7 job → product=42.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential digit-serial multiplier controller.
//   state_t : controller FSM states (IDLE, RUN, DONE), 2-bit encoding
//   DIGIT_W : width of one operand digit fed to the multiplier slice
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIGIT_W = 2;

endpackage

// File: rtl/mult_digit_2x2.sv
// 2-bit x 2-bit unsigned combinational multiplier built from gate primitives
// so that every internal net is an enumerable fault site.
//   a : 2-bit multiplicand digit
//   b : 2-bit multiplier digit
//   p : 4-bit product a*b
module mult_digit_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic t_a1b0;
    logic t_a0b1;
    logic t_a1b1;
    logic c1;

    and g_p0  (p[0],   a[0], b[0]);
    and g_t10 (t_a1b0, a[1], b[0]);
    and g_t01 (t_a0b1, a[0], b[1]);
    xor g_p1  (p[1],   t_a1b0, t_a0b1);
    and g_c1  (c1,     t_a1b0, t_a0b1);
    and g_t11 (t_a1b1, a[1], b[1]);
    xor g_p2  (p[2],   t_a1b1, c1);
    and g_p3  (p[3],   t_a1b1, c1);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller computing an unsigned W x W product by walking a
// single 2x2 multiplier slice over every digit pair and accumulating the
// shifted partial products. Fixed latency of (W/2)^2 cycles in RUN.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake, op_a/op_b sampled on accept
//   out_valid / out_ready: result handshake, product held until taken
//   product              : registered 2W-bit result
//   busy                 : high while the digit loop is running
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int unsigned N  = W / DIGIT_W;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * W;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   product_q;
    logic [CW-1:0]   i_q;
    logic [CW-1:0]   j_q;

    logic [1:0]      a_dig;
    logic [1:0]      b_dig;
    logic [3:0]      slice;
    logic [CW:0]     pos;
    logic [PW-1:0]   partial;
    logic [PW-1:0]   acc_next;
    logic            accept;
    logic            last_pair;

    // Digit select by shifting: digit k sits at bit 2k.
    assign a_dig = 2'(a_q >> {i_q, 1'b0});
    assign b_dig = 2'(b_q >> {j_q, 1'b0});

    mult_digit_2x2 u_digit (
        .a (a_dig),
        .b (b_dig),
        .p (slice)
    );

    // i+j needs one extra bit; the digit weight is 2*(i+j) bits.
    assign pos       = {1'b0, i_q} + {1'b0, j_q};
    assign partial   = PW'(slice) << {pos, 1'b0};
    assign acc_next  = acc_q + partial;
    assign last_pair = (i_q == LAST) && (j_q == LAST);

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
        end else if (accept) begin
            // accept can only happen in IDLE or DONE, so it covers the
            // back-to-back DONE->RUN path as well as IDLE->RUN.
            state_q <= RUN;
            a_q     <= op_a;
            b_q     <= op_b;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    acc_q <= acc_next;
                    if (last_pair) begin
                        state_q   <= DONE;
                        product_q <= acc_next;
                    end else if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl (W=8): directed scenarios plus
// randomized jobs, expected products from plain integer multiplication.
module tb_mult_seq_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned LAT = (W / 2) * (W / 2);

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int checks;
    int failures;

    mult_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands and returns 1 time unit after the accepting edge.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("start_ready", 32'(in_ready), 1);
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts cycles from accept to out_valid and checks the result.
    task automatic wait_result(input string tag, input logic [31:0] exp);
        int cnt;
        int busy_cnt;
        cnt      = 0;
        busy_cnt = 0;
        while (!out_valid && cnt < 100) begin
            if (busy) busy_cnt++;
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), LAT);
        check({tag, "_busy"}, 32'(busy_cnt), LAT);
        check({tag, "_product"}, 32'(product), exp);
    endtask

    logic [2*W-1:0] held;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_product", 32'(product), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        tick();

        // 13x11 with out_ready high, then one IDLE cycle
        start(8'd13, 8'd11);
        wait_result("m13x11", 143);
        tick();
        check("idle_after_out_valid", 32'(out_valid), 0);
        check("idle_after_busy", 32'(busy), 0);
        check("idle_after_in_ready", 32'(in_ready), 1);

        start(8'd255, 8'd255);
        wait_result("m255x255", 32'h0000_FE01);
        tick();

        start(8'd0, 8'd200);
        wait_result("m0x200", 0);
        tick();

        // Backpressure, then back-to-back accept with the output handshake
        out_ready = 1'b0;
        start(8'd37, 8'd201);
        wait_result("m37x201", 37 * 201);
        held     = product;
        op_a     = 8'd7;
        op_b     = 8'd9;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_product_stable", 32'(product), 32'(held));
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        wait_result("m7x9", 63);
        tick();

        // in_valid during RUN must be ignored
        start(8'd10, 8'd10);
        op_a = 8'd3;
        op_b = 8'd3;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k >= 2);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        check("ign_out_valid", 32'(out_valid), 1);
        check("ign_product", 32'(product), 100);
        tick();
        tick();
        check("ign_no_second_job", 32'(busy), 0);
        check("ign_idle_out_valid", 32'(out_valid), 0);

        // Reset in the middle of RUN
        start(8'd99, 8'd77);
        for (int k = 0; k < 7; k++) tick();
        check("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_product", 32'(product), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        #10;
        rst_n = 1'b1;
        tick();
        start(8'd6, 8'd7);
        wait_result("m6x7", 42);
        tick();

        // Randomized jobs with random consumer stall
        for (int t = 0; t < 12; t++) begin
            int stall;
            ra        = 8'($urandom);
            rb        = 8'($urandom);
            stall     = int'($urandom_range(0, 3));
            out_ready = (stall == 0);
            start(ra, rb);
            wait_result("rand", 32'(ra) * 32'(rb));
            for (int k = 0; k < stall; k++) begin
                tick();
                check("rand_hold", 32'(product), 32'(ra) * 32'(rb));
            end
            out_ready = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
